// File: rtl/udma_jtag_fifo_rx_pack_if.sv
// rtl/udma_jtag_fifo_rx_pack_if.sv - chunk input, packed-word output and status bundle
interface udma_jtag_fifo_rx_pack_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clr_i;
  logic [31:0]   in_data_i;
  logic [1:0]    in_size_i;
  logic          in_valid_i;
  logic          flush_i;
  logic [31:0]   out_data_o;
  logic [2:0]    out_bytes_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [CW-1:0] occupancy_o;
  logic          overflow_o;
  logic [7:0]    drop_cnt_o;

  modport slave (
    input  clr_i, in_data_i, in_size_i, in_valid_i, flush_i, out_ready_i,
    output out_data_o, out_bytes_o, out_valid_o, occupancy_o, overflow_o, drop_cnt_o
  );

  modport master (
    output clr_i, in_data_i, in_size_i, in_valid_i, flush_i, out_ready_i,
    input  out_data_o, out_bytes_o, out_valid_o, occupancy_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/udma_jtag_fifo_rx_pack.sv
// rtl/udma_jtag_fifo_rx_pack.sv - packs 8/16/32-bit JTAG chunks into 32-bit words behind a FWFT FIFO
module udma_jtag_fifo_rx_pack #(
  parameter int DEPTH = 4
) (
  input logic                     jtag_tck_i,
  input logic                     jtag_trstn_i,
  udma_jtag_fifo_rx_pack_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   acc_data;
  logic [2:0]    acc_bytes;
  logic          pend_flush;
  logic [31:0]   mem_data [DEPTH];
  logic [2:0]    mem_bytes [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    drop_cnt;

  logic [31:0]   chunk_data;
  logic [2:0]    chunk_bytes;
  logic [31:0]   acc_nxt;
  logic [2:0]    bytes_nxt;
  logic [3:0]    fill;
  logic          pend_flush_nxt;
  logic          push;
  logic [31:0]   push_data;
  logic [2:0]    push_bytes;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;

  always_comb begin
    case (bus.in_size_i)
      2'd0: begin
        chunk_bytes = 3'd1;
        chunk_data  = {24'd0, bus.in_data_i[7:0]};
      end
      2'd1: begin
        chunk_bytes = 3'd2;
        chunk_data  = {16'd0, bus.in_data_i[15:0]};
      end
      default: begin
        chunk_bytes = 3'd4;
        chunk_data  = bus.in_data_i;
      end
    endcase
  end

  always_comb begin
    acc_nxt        = acc_data;
    bytes_nxt      = acc_bytes;
    pend_flush_nxt = 1'b0;
    push           = 1'b0;
    push_data      = '0;
    push_bytes     = '0;
    fill           = '0;
    // A held full chunk or a deferred flush owns the single push slot first.
    if (acc_bytes == 3'd4 || (pend_flush && acc_bytes != 3'd0)) begin
      push       = 1'b1;
      push_data  = acc_data;
      push_bytes = acc_bytes;
      acc_nxt    = '0;
      bytes_nxt  = '0;
    end
    if (bus.in_valid_i) begin
      fill = {1'b0, bytes_nxt} + {1'b0, chunk_bytes};
      if (fill > 4'd4) begin
        push       = 1'b1;
        push_data  = acc_nxt;
        push_bytes = bytes_nxt;
        acc_nxt    = chunk_data;
        bytes_nxt  = chunk_bytes;
      end else begin
        acc_nxt   = acc_nxt | (chunk_data << {bytes_nxt, 3'b000});
        bytes_nxt = fill[2:0];
        if (bytes_nxt == 3'd4 && !push) begin
          push       = 1'b1;
          push_data  = acc_nxt;
          push_bytes = 3'd4;
          acc_nxt    = '0;
          bytes_nxt  = '0;
        end
      end
    end
    if (bus.flush_i && bytes_nxt != 3'd0) begin
      if (!push) begin
        push       = 1'b1;
        push_data  = acc_nxt;
        push_bytes = bytes_nxt;
        acc_nxt    = '0;
        bytes_nxt  = '0;
      end else begin
        pend_flush_nxt = 1'b1;
      end
    end
  end

  assign pop     = (count != '0) && bus.out_ready_i;
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge jtag_tck_i or negedge jtag_trstn_i) begin
    if (!jtag_trstn_i) begin
      acc_data   <= '0;
      acc_bytes  <= '0;
      pend_flush <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i]  <= '0;
        mem_bytes[i] <= '0;
      end
    end else if (bus.clr_i) begin
      acc_data   <= '0;
      acc_bytes  <= '0;
      pend_flush <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i]  <= '0;
        mem_bytes[i] <= '0;
      end
    end else begin
      acc_data   <= acc_nxt;
      acc_bytes  <= bytes_nxt;
      pend_flush <= pend_flush_nxt;
      if (push_ok) begin
        mem_data[wr_ptr]  <= push_data;
        mem_bytes[wr_ptr] <= push_bytes;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (!push_ok && pop) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid_o = (count != '0);
  assign bus.out_data_o  = (count != '0) ? mem_data[rd_ptr] : '0;
  assign bus.out_bytes_o = (count != '0) ? mem_bytes[rd_ptr] : '0;
  assign bus.occupancy_o = count;
  assign bus.overflow_o  = overflow;
  assign bus.drop_cnt_o  = drop_cnt;
endmodule

// File: tb/tb_udma_jtag_fifo_rx_pack.sv
// tb/tb_udma_jtag_fifo_rx_pack.sv - directed vector table plus randomized run against a byte-queue model
module tb_udma_jtag_fifo_rx_pack;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  udma_jtag_fifo_rx_pack_if #(.DEPTH(DEPTH)) bus ();

  udma_jtag_fifo_rx_pack #(.DEPTH(DEPTH)) dut (
    .jtag_tck_i   (clk),
    .jtag_trstn_i (rst_n),
    .bus          (bus)
  );

  typedef struct {
    logic        clr;
    logic        v;
    logic [1:0]  sz;
    logic [31:0] d;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  eb;
    logic [2:0]  eo;
    logic        eovf;
    logic [7:0]  edrop;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  bytes;
  } word_t;

  int n_checks = 0;
  int n_fail = 0;

  byte unsigned acc_q[$];
  bit           m_pflush;
  word_t        m_fifo[$];
  bit           m_ovf;
  int           m_drop;

  vec_t tbl[$];

  function automatic vec_t mk(logic clr, logic v, logic [1:0] sz, logic [31:0] d, logic fl, logic rdy,
                              logic ev, logic [31:0] ed, logic [2:0] eb, logic [2:0] eo,
                              logic eovf, logic [7:0] edrop);
    vec_t r;
    r.clr = clr; r.v = v; r.sz = sz; r.d = d; r.fl = fl; r.rdy = rdy;
    r.ev = ev; r.ed = ed; r.eb = eb; r.eo = eo; r.eovf = eovf; r.edrop = edrop;
    return r;
  endfunction

  function automatic word_t pack(byte unsigned q[$]);
    word_t w;
    w.data  = '0;
    w.bytes = 3'(q.size());
    for (int i = 0; i < q.size(); i++) w.data = w.data | (32'(q[i]) << (8 * i));
    return w;
  endfunction

  task automatic model_reset();
    acc_q.delete();
    m_fifo.delete();
    m_pflush = 0;
    m_ovf = 0;
    m_drop = 0;
  endtask

  // Byte-level view: acc is a list of pending bytes, at most one word leaves per cycle.
  task automatic model_cycle(input bit clr, input bit v, input logic [1:0] sz, input logic [31:0] d,
                             input bit fl, input bit rdy);
    word_t w;
    bit emit;
    bit pop;
    int n;
    byte unsigned chunk[$];
    if (clr) begin
      model_reset();
      return;
    end
    pop = (m_fifo.size() > 0) && rdy;
    emit = 0;
    if (acc_q.size() == 4 || (m_pflush && acc_q.size() > 0)) begin
      w = pack(acc_q);
      emit = 1;
      acc_q.delete();
    end
    m_pflush = 0;
    if (v) begin
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      for (int i = 0; i < n; i++) chunk.push_back(d[8*i +: 8]);
      if (acc_q.size() + n > 4) begin
        w = pack(acc_q);
        emit = 1;
        acc_q = chunk;
      end else begin
        foreach (chunk[i]) acc_q.push_back(chunk[i]);
        if (acc_q.size() == 4 && !emit) begin
          w = pack(acc_q);
          emit = 1;
          acc_q.delete();
        end
      end
    end
    if (fl && acc_q.size() > 0) begin
      if (!emit) begin
        w = pack(acc_q);
        emit = 1;
        acc_q.delete();
      end else begin
        m_pflush = 1;
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (emit) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
      else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input bit clr, input bit v, input logic [1:0] sz, input logic [31:0] d,
                      input bit fl, input bit rdy);
    bus.clr_i = clr;
    bus.in_valid_i = v;
    bus.in_size_i = sz;
    bus.in_data_i = d;
    bus.flush_i = fl;
    bus.out_ready_i = rdy;
    @(posedge clk);
    #1;
    model_cycle(clr, v, sz, d, fl, rdy);
    bus.clr_i = 0;
    bus.in_valid_i = 0;
    bus.flush_i = 0;
    bus.out_ready_i = 0;
  endtask

  task automatic chk_vs_model(input string tag);
    chk({tag, " valid"}, 32'(bus.out_valid_o), 32'(m_fifo.size() > 0));
    chk({tag, " data"}, bus.out_data_o, (m_fifo.size() > 0) ? m_fifo[0].data : 32'd0);
    chk({tag, " bytes"}, 32'(bus.out_bytes_o), (m_fifo.size() > 0) ? 32'(m_fifo[0].bytes) : 32'd0);
    chk({tag, " occupancy"}, 32'(bus.occupancy_o), 32'(m_fifo.size()));
    chk({tag, " overflow"}, 32'(bus.overflow_o), 32'(m_ovf));
    chk({tag, " drop_cnt"}, 32'(bus.drop_cnt_o), 32'(m_drop));
  endtask

  initial begin
    bus.clr_i = 0;
    bus.in_valid_i = 0;
    bus.in_size_i = 0;
    bus.in_data_i = 0;
    bus.flush_i = 0;
    bus.out_ready_i = 0;
    model_reset();

    // four bytes -> one word
    tbl.push_back(mk(0,1,0,'h11,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,'h22,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,'h33,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,'h44,0,0, 1,'h44332211,4,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0));
    // byte + halfword + flush, upper garbage must be masked
    tbl.push_back(mk(0,1,0,'hFFFFFFAA,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,'h1234BEEF,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 1,'h00BEEFAA,3,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0));
    // halfword then word: partial push, full word next cycle
    tbl.push_back(mk(0,1,1,'h1234,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,2,'hCAFEF00D,0,0, 1,'h1234,2,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,'h1234,2,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 1,'hCAFEF00D,4,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0));
    // overflow: six words into a 4-deep FIFO, size 3 behaves as 32-bit
    tbl.push_back(mk(0,1,2,'hA0000001,0,0, 1,'hA0000001,4,1,0,0));
    tbl.push_back(mk(0,1,3,'hA0000002,0,0, 1,'hA0000001,4,2,0,0));
    tbl.push_back(mk(0,1,2,'hA0000003,0,0, 1,'hA0000001,4,3,0,0));
    tbl.push_back(mk(0,1,3,'hA0000004,0,0, 1,'hA0000001,4,4,0,0));
    tbl.push_back(mk(0,1,2,'hA0000005,0,0, 1,'hA0000001,4,4,1,1));
    tbl.push_back(mk(0,1,2,'hA0000006,0,0, 1,'hA0000001,4,4,1,2));
    tbl.push_back(mk(0,0,0,0,0,1, 1,'hA0000002,4,3,1,2));
    tbl.push_back(mk(0,0,0,0,0,1, 1,'hA0000003,4,2,1,2));
    tbl.push_back(mk(0,0,0,0,0,1, 1,'hA0000004,4,1,1,2));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,1,2));
    // push while full with a simultaneous pop, then clr with a chunk+flush
    tbl.push_back(mk(0,1,2,'hB0000001,0,0, 1,'hB0000001,4,1,1,2));
    tbl.push_back(mk(0,1,2,'hB0000002,0,0, 1,'hB0000001,4,2,1,2));
    tbl.push_back(mk(0,1,2,'hB0000003,0,0, 1,'hB0000001,4,3,1,2));
    tbl.push_back(mk(0,1,2,'hB0000004,0,0, 1,'hB0000001,4,4,1,2));
    tbl.push_back(mk(0,1,2,'hB0000005,0,1, 1,'hB0000002,4,4,1,2));
    tbl.push_back(mk(1,1,2,'hDEADBEEF,1,1, 0,0,0,0,0,0));
    // a=3, halfword with flush: partial now, flushed halfword next cycle
    tbl.push_back(mk(0,1,0,'h01,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,'h0302,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,'h0504,1,0, 1,'h00030201,3,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,'h00030201,3,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 1,'h00000504,2,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0));
    // clr mid-packet must discard the accumulated byte
    tbl.push_back(mk(0,1,0,'h77,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,'h9988,1,0, 1,'h00009988,2,1,0,0));

    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 32'(bus.out_valid_o), 0);
    chk("reset data", bus.out_data_o, 0);
    chk("reset bytes", 32'(bus.out_bytes_o), 0);
    chk("reset occupancy", 32'(bus.occupancy_o), 0);
    chk("reset overflow", 32'(bus.overflow_o), 0);
    chk("reset drop_cnt", 32'(bus.drop_cnt_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].clr, tbl[i].v, tbl[i].sz, tbl[i].d, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("row%0d valid", i), 32'(bus.out_valid_o), 32'(tbl[i].ev));
      chk($sformatf("row%0d data", i), bus.out_data_o, tbl[i].ed);
      chk($sformatf("row%0d bytes", i), 32'(bus.out_bytes_o), 32'(tbl[i].eb));
      chk($sformatf("row%0d occupancy", i), 32'(bus.occupancy_o), 32'(tbl[i].eo));
      chk($sformatf("row%0d overflow", i), 32'(bus.overflow_o), 32'(tbl[i].eovf));
      chk($sformatf("row%0d drop_cnt", i), 32'(bus.drop_cnt_o), 32'(tbl[i].edrop));
    end

    // async reset mid-packet with a word stored
    step(0, 1, 2'd0, 32'h55, 0, 0);
    chk("pre-reset occupancy", 32'(bus.occupancy_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_vs_model("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 2'd1, 32'h2211, 1, 0);
    chk("post-reset data", bus.out_data_o, 32'h00002211);
    chk("post-reset bytes", 32'(bus.out_bytes_o), 2);
    step(0, 0, 2'd0, 0, 0, 1);

    for (int c = 0; c < 800; c++) begin
      bit v, fl, rdy, clr;
      v   = ($urandom % 2) == 0;
      fl  = ($urandom % 8) == 0;
      rdy = ((c / 100) % 2 == 1) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      clr = ($urandom % 150) == 0;
      step(clr, v, 2'($urandom % 4), $urandom, fl, rdy);
      chk_vs_model($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
